pe_mac_sequencer: RTL and testbench

//  Consumer end of the 4-cycle PE step timing: runs one signed MAC per step in four phases
//  (LOAD, MUL, ACC, WB) over cfg_steps operand pairs, then presents the accumulated result.

---
 rtl/pe_pkg.sv | 16 +
 rtl/pe_mac_sequencer_if.sv | 26 ++
 rtl/pe_phase_cnt.sv | 29 ++
 rtl/pe_mac_sequencer.sv | 151 +++++++++++++++
 tb/tb_pe_mac_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE MAC sequencer: controller states and the four
// phase codes of one MAC step.
package pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam logic [1:0] PH_LOAD = 2'd0;
    localparam logic [1:0] PH_MUL  = 2'd1;
    localparam logic [1:0] PH_ACC  = 2'd2;
    localparam logic [1:0] PH_WB   = 2'd3;

endpackage

// File: rtl/pe_mac_sequencer_if.sv
// Operand feed and result collector bundle of the PE MAC sequencer.
interface pe_mac_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
);
    // Both channels: a transfer happens on a rising edge where valid && ready;
    // the source holds valid and payload stable until that edge.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_acc
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_acc
    );

endinterface

// File: rtl/pe_phase_cnt.sv
// Two-bit phase counter for the four-phase MAC step; wraps WB -> LOAD.
module pe_phase_cnt (
    input  logic       clk,
    input  logic       clr_i,
    input  logic       adv_i,
    output logic [1:0] phase_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_o = cnt_q;

endmodule

// File: rtl/pe_mac_sequencer.sv
// Runs one signed MAC per four-phase step (LOAD, MUL, ACC, WB) over a latched
// number of operand pairs, then offers the accumulated result to the collector.
module pe_mac_sequencer
    import pe_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int STEPS_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STEPS_W-1:0] cfg_steps,
    pe_mac_sequencer_if.slave  bus,
    output logic               busy,
    output logic               done,
    output logic [1:0]         phase,
    output state_e             state_dbg
);

    localparam int PROD_W = 2 * DATA_W;

    state_e                     state_q, state_d;
    logic [STEPS_W-1:0]         steps_q, steps_d;
    logic [STEPS_W-1:0]         step_cnt_q, step_cnt_d;
    logic signed [DATA_W-1:0]   a_q, a_d;
    logic signed [DATA_W-1:0]   b_q, b_d;
    logic signed [PROD_W-1:0]   prod_q, prod_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]           out_acc_q, out_acc_d;
    logic                       done_q, done_d;

    logic [1:0] phase_q;
    logic       ph_clr;
    logic       ph_adv;
    logic       in_ready_w;
    logic       out_valid_w;

    // Phase counter is held at LOAD whenever no step is in flight.
    pe_phase_cnt u_phase_cnt (
        .clk     (clk),
        .clr_i   (rst | ph_clr),
        .adv_i   (ph_adv),
        .phase_o (phase_q)
    );

    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        step_cnt_d  = step_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        out_acc_d   = out_acc_q;
        done_d      = 1'b0;
        ph_clr      = 1'b0;
        ph_adv      = 1'b0;
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ph_clr = 1'b1;
                if (start) begin
                    state_d    = ST_RUN;
                    steps_d    = (cfg_steps == '0) ? STEPS_W'(1) : cfg_steps;
                    step_cnt_d = '0;
                    acc_d      = '0;
                end
            end

            ST_RUN: begin
                case (phase_q)
                    PH_LOAD: begin
                        in_ready_w = 1'b1;
                        if (bus.in_valid) begin
                            a_d    = bus.in_a;
                            b_d    = bus.in_b;
                            ph_adv = 1'b1;
                        end
                    end
                    PH_MUL: begin
                        prod_d = PROD_W'(a_q) * PROD_W'(b_q);
                        ph_adv = 1'b1;
                    end
                    PH_ACC: begin
                        // Sign-extend the product; the sum wraps at ACC_W bits.
                        acc_d  = acc_q + ACC_W'(prod_q);
                        ph_adv = 1'b1;
                    end
                    default: begin
                        ph_adv = 1'b1;
                        if (step_cnt_q == steps_q - STEPS_W'(1)) begin
                            state_d   = ST_OUT;
                            out_acc_d = acc_q;
                        end else begin
                            step_cnt_d = step_cnt_q + STEPS_W'(1);
                        end
                    end
                endcase
            end

            ST_OUT: begin
                ph_clr      = 1'b1;
                out_valid_w = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            steps_q    <= '0;
            step_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            out_acc_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            steps_q    <= steps_d;
            step_cnt_q <= step_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            out_acc_q  <= out_acc_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_acc   = out_acc_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign phase         = (state_q == ST_RUN) ? phase_q : PH_LOAD;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Bench for pe_mac_sequencer: a 24-bit and a 16-bit accumulator instance share
// one stimulus stream; results come from a sum-of-products model.
module tb_pe_mac_sequencer;
    import pe_pkg::*;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 24;
    localparam int ACC16_W = 16;
    localparam int STEPS_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [STEPS_W-1:0] cfg_steps;
    logic               in_valid;
    logic [DATA_W-1:0]  in_a;
    logic [DATA_W-1:0]  in_b;
    logic               out_ready;

    logic       busy24, done24, busy16, done16;
    logic [1:0] phase24, phase16;
    state_e     st24, st16;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [ACC_W-1:0]   exp_q[$];
    logic [ACC16_W-1:0] exp16_q[$];
    int pa[16];
    int pb[16];

    pe_mac_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W))   bus24();
    pe_mac_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC16_W)) bus16();

    assign bus24.in_valid  = in_valid;
    assign bus24.in_a      = in_a;
    assign bus24.in_b      = in_b;
    assign bus24.out_ready = out_ready;
    assign bus16.in_valid  = in_valid;
    assign bus16.in_a      = in_a;
    assign bus16.in_b      = in_b;
    assign bus16.out_ready = out_ready;

    pe_mac_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .STEPS_W(STEPS_W)) dut24 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_steps (cfg_steps),
        .bus       (bus24),
        .busy      (busy24),
        .done      (done24),
        .phase     (phase24),
        .state_dbg (st24)
    );

    pe_mac_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC16_W), .STEPS_W(STEPS_W)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_steps (cfg_steps),
        .bus       (bus16),
        .busy      (busy16),
        .done      (done16),
        .phase     (phase16),
        .state_dbg (st16)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_pairs(input int n);
        for (int k = 0; k < n; k++) begin
            pa[k] = int'($urandom_range(0, 255)) - 128;
            pb[k] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // ---------------- driver: one complete job ----------------
    // Entered and left at a falling edge; leaves in the done cycle when b2b_next.
    task automatic run_job(input int steps_cfg, input int stall_step, input int stall_len,
                           input int out_wait, input bit poke_start, input bit b2b_next);
        int n;
        int t0;
        int lat;
        int guard;
        int stalls;
        longint sum;
        logic [ACC_W-1:0]   e24;
        logic [ACC16_W-1:0] e16;

        n   = (steps_cfg == 0) ? 1 : steps_cfg;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            sum += longint'(pa[k]) * longint'(pb[k]);
        end
        exp_q.push_back(sum[ACC_W-1:0]);
        exp16_q.push_back(sum[ACC16_W-1:0]);
        stalls = (stall_step < n) ? stall_len : 0;

        check_eq("idle_before_start", 32'(st24), 32'(ST_IDLE));
        out_ready = (out_wait == 0);
        start     = 1'b1;
        cfg_steps = STEPS_W'(steps_cfg);
        tick();
        start = 1'b0;
        t0    = cyc;
        check_eq("busy_after_start", 32'(busy24), 1);
        check_eq("done_low_in_job", 32'(done24), 0);

        for (int k = 0; k < n; k++) begin
            guard = 0;
            while (!bus24.in_ready && guard < 8) begin
                tick();
                guard++;
            end
            check_eq("in_ready_wait", 32'(bus24.in_ready), 1);
            if (k == stall_step) begin
                for (int s = 0; s < stall_len; s++) begin
                    in_valid = 1'b0;
                    tick();
                    check_eq("stall_phase", 32'(phase24), 0);
                    check_eq("stall_in_ready", 32'(bus24.in_ready), 1);
                end
            end
            in_valid = 1'b1;
            in_a     = DATA_W'(pa[k]);
            in_b     = DATA_W'(pb[k]);
            tick();
            check_eq("phase_after_load", 32'(phase24), 1);
        end

        guard = 0;
        while (!bus24.out_valid && guard < 16) begin
            tick();
            guard++;
        end
        lat = cyc - t0;
        check_eq("out_valid_wait", 32'(bus24.out_valid), 1);
        check_eq("latency", 32'(lat), 32'(4 * n + stalls));
        e24 = exp_q.pop_front();
        e16 = exp16_q.pop_front();
        check_eq("out_acc24", 32'(bus24.out_acc), 32'(e24));
        check_eq("out_acc16", 32'(bus16.out_acc), 32'(e16));
        check_eq("out_valid16", 32'(bus16.out_valid), 1);
        check_eq("phase_in_out", 32'(phase24), 0);
        check_eq("in_ready_in_out", 32'(bus24.in_ready), 0);

        for (int w = 0; w < out_wait; w++) begin
            if (poke_start && w == 1) start = 1'b1;
            tick();
            start = 1'b0;
            check_eq("out_hold_valid", 32'(bus24.out_valid), 1);
            check_eq("out_hold_acc", 32'(bus24.out_acc), 32'(e24));
            check_eq("out_hold_state", 32'(st24), 32'(ST_OUT));
            check_eq("out_hold_busy", 32'(busy24), 1);
        end

        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("done_pulse", 32'(done24), 1);
        check_eq("done_pulse16", 32'(done16), 1);
        check_eq("out_valid_drop", 32'(bus24.out_valid), 0);
        check_eq("busy_drop", 32'(busy24), 0);
        check_eq("state_idle_after", 32'(st24), 32'(ST_IDLE));

        if (!b2b_next) begin
            tick();
            check_eq("done_one_cycle", 32'(done24), 0);
            check_eq("still_idle", 32'(st24), 32'(ST_IDLE));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int steps;
        bit b2b;

        rst       = 1'b1;
        start     = 1'b0;
        cfg_steps = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check_eq("rst_in_ready", 32'(bus24.in_ready), 0);
        check_eq("rst_out_valid", 32'(bus24.out_valid), 0);
        check_eq("rst_out_acc", 32'(bus24.out_acc), 0);
        check_eq("rst_busy", 32'(busy24), 0);
        check_eq("rst_done", 32'(done24), 0);
        check_eq("rst_phase", 32'(phase24), 0);
        check_eq("rst_state", 32'(st24), 32'(ST_IDLE));

        // Three steps, in_valid held high: 2*3 - 4*5 + 7*7 = 35.
        pa[0] = 2;  pb[0] = 3;
        pa[1] = -4; pb[1] = 5;
        pa[2] = 7;  pb[2] = 7;
        run_job(3, 99, 0, 0, 1'b0, 1'b0);

        // Reset two cycles in the middle of a job.
        rand_pairs(5);
        start     = 1'b1;
        cfg_steps = 8'd5;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = DATA_W'(pa[0]);
        in_b     = DATA_W'(pb[0]);
        repeat (6) tick();
        rst = 1'b1;
        repeat (2) tick();
        check_eq("midrst_in_ready", 32'(bus24.in_ready), 0);
        check_eq("midrst_out_valid", 32'(bus24.out_valid), 0);
        check_eq("midrst_out_acc", 32'(bus24.out_acc), 0);
        check_eq("midrst_out_acc16", 32'(bus16.out_acc), 0);
        check_eq("midrst_busy", 32'(busy24), 0);
        check_eq("midrst_done", 32'(done24), 0);
        check_eq("midrst_phase", 32'(phase24), 0);
        check_eq("midrst_state", 32'(st24), 32'(ST_IDLE));
        rst      = 1'b0;
        in_valid = 1'b1;
        tick();
        check_eq("postrst_busy", 32'(busy24), 0);
        check_eq("postrst_in_ready", 32'(bus24.in_ready), 0);
        in_valid = 1'b0;

        // cfg_steps = 0 behaves as a single step: (-8)*(-8) = 64.
        pa[0] = -8; pb[0] = -8;
        run_job(0, 99, 0, 0, 1'b0, 1'b0);

        // Three-cycle bubble in the second step.
        rand_pairs(3);
        run_job(3, 1, 3, 0, 1'b0, 1'b0);

        // Collector stalls five cycles; a start during OUT is ignored.
        rand_pairs(4);
        run_job(4, 99, 0, 5, 1'b1, 1'b0);

        // 3 x 127*127 = 48387: fits 24 bits, wraps to 0xBD03 in 16 bits.
        for (int k = 0; k < 3; k++) begin
            pa[k] = 127;
            pb[k] = 127;
        end
        run_job(3, 99, 0, 0, 1'b0, 1'b1);
        rand_pairs(2);
        run_job(2, 99, 0, 1, 1'b0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 10; j++) begin
            steps = int'($urandom_range(0, 12));
            rand_pairs((steps == 0) ? 1 : steps);
            b2b = (j != 9) && ($urandom_range(0, 1) == 1);
            run_job(steps, int'($urandom_range(0, 11)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, b2b);
        end

        check_eq("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
